// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: bit positions, receive FSM states and the
// syndrome/correction helpers used by both encoder and decoder sides.
package hamming_pkg;

    // Index into cw[6:0]; cw[p-1] holds Hamming position p.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DECODE,
        ST_PUSH
    } rx_state_e;

    typedef enum logic {
        PH_LO,
        PH_HI
    } nib_phase_e;

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic s0, s1, s2;
        s0 = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
        s1 = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
        s2 = cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3];
        return {s2, s1, s0};
    endfunction

    // Nonzero syndrome names the 1-based position to flip.
    function automatic logic [6:0] correct(input logic [6:0] cw);
        logic [2:0] s;
        logic [6:0] fixed;
        s     = syndrome(cw);
        fixed = cw;
        if (s != 3'd0) begin
            fixed[s - 3'd1] = ~cw[s - 3'd1];
        end
        return fixed;
    endfunction

    function automatic logic [3:0] extract_nibble(input logic [6:0] cw);
        return {cw[D3], cw[D2], cw[D1], cw[D0]};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational single-error correction of one Hamming(7,4) codeword.
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [6:0] cw,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        err    = (syndrome(cw) != 3'd0);
        nibble = extract_nibble(correct(cw));
    end

endmodule

// File: rtl/hamming_rx_scheduler.sv
// Receive-side Hamming(7,4) controller: frames serial bits into codewords,
// corrects them, pairs nibbles into bytes and queues them behind valid/ready.
module hamming_rx_scheduler
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sync_clr,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic             overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    rx_state_e                        state_q, state_d;
    nib_phase_e                       phase_q, phase_d;
    logic [2:0]                       bit_idx_q, bit_idx_d;
    logic [6:0]                       cw_q, cw_d;
    logic [3:0]                       lo_nib_q, lo_nib_d;
    logic [3:0]                       hi_nib_q, hi_nib_d;
    logic [IDLE_W-1:0]                idle_q, idle_d;
    logic [CNT_W-1:0]                 corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]                 frame_err_q, frame_err_d;
    logic                             overflow_q, overflow_d;
    logic [FIFO_DEPTH-1:0][7:0]       mem_q, mem_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                   count_q, count_d;

    logic       push_req;
    logic       do_push;
    logic       do_pop;
    logic       fifo_full;
    logic [3:0] dec_nib;
    logic       dec_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hamming74_correct u_correct (
        .cw     (cw_q),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    // Framing / sequencing FSM. Bit intake is shared by all states so a bit
    // landing during DECODE or PUSH starts the next codeword.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_idx_d   = bit_idx_q;
        cw_d        = cw_q;
        lo_nib_d    = lo_nib_q;
        hi_nib_d    = hi_nib_q;
        idle_d      = idle_q;
        corr_cnt_d  = corr_cnt_q;
        frame_err_d = frame_err_q;
        push_req    = 1'b0;

        if (sync_clr) begin
            state_d   = ST_IDLE;
            phase_d   = PH_LO;
            bit_idx_d = '0;
            idle_d    = '0;
        end else if (ena) begin
            if (bit_valid) begin
                cw_d[bit_idx_q] = bit_in;
                bit_idx_d       = (bit_idx_q == 3'd6) ? 3'd0 : bit_idx_q + 3'd1;
                idle_d          = '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bit_valid) state_d = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (bit_valid) begin
                        if (bit_idx_q == 3'd6) state_d = ST_DECODE;
                    end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        bit_idx_d   = '0;
                        idle_d      = '0;
                        state_d     = ST_IDLE;
                        frame_err_d = sat_inc(frame_err_q);
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec_err) corr_cnt_d = sat_inc(corr_cnt_q);
                    if (phase_q == PH_LO) begin
                        lo_nib_d = dec_nib;
                        phase_d  = PH_HI;
                        state_d  = (bit_idx_d != 3'd0) ? ST_COLLECT : ST_IDLE;
                    end else begin
                        hi_nib_d = dec_nib;
                        state_d  = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    push_req = 1'b1;
                    phase_d  = PH_LO;
                    state_d  = (bit_idx_d != 3'd0) ? ST_COLLECT : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Byte FIFO; a full FIFO still accepts a push when the head leaves that cycle.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        do_pop    = (count_q != '0) && m_ready;
        do_push   = push_req && (!fifo_full || do_pop);

        if (push_req && !do_push) overflow_d = 1'b1;
        if (do_push) begin
            mem_d[wr_ptr_q] = {hi_nib_q, lo_nib_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_LO;
            bit_idx_q   <= '0;
            cw_q        <= '0;
            lo_nib_q    <= '0;
            hi_nib_q    <= '0;
            idle_q      <= '0;
            corr_cnt_q  <= '0;
            frame_err_q <= '0;
            overflow_q  <= 1'b0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            cw_q        <= cw_d;
            lo_nib_q    <= lo_nib_d;
            hi_nib_q    <= hi_nib_d;
            idle_q      <= idle_d;
            corr_cnt_q  <= corr_cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign m_valid       = (count_q != '0);
    assign m_data        = m_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign corr_cnt      = corr_cnt_q;
    assign frame_err_cnt = frame_err_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_hamming_rx_scheduler.sv
// Directed bench for hamming_rx_scheduler: table of codeword pairs plus
// hand-written timeout, overflow, sync_clr, ena and reset sequences.
module tb_hamming_rx_scheduler;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             bit_in;
    logic             bit_valid;
    logic             sync_clr;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] frame_err_cnt;
    logic             overflow;

    int errors;
    int checks;
    int exp_corr;

    typedef struct {
        logic [6:0] lo_cw;
        logic [6:0] hi_cw;
        logic [7:0] exp_byte;
        int         corr_inc;
    } vec_t;

    vec_t vecs [6];

    hamming_rx_scheduler #(
        .FIFO_DEPTH (2),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .sync_clr      (sync_clr),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .corr_cnt      (corr_cnt),
        .frame_err_cnt (frame_err_cnt),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_cw(input logic [6:0] cw);
        for (int i = 0; i < 7; i++) send_bit(cw[i]);
    endtask

    // Assumes an empty FIFO and m_ready=1: byte visible for exactly one cycle,
    // two edges after the 14th bit.
    task automatic send_pair(input logic [6:0] lo, input logic [6:0] hi,
                             input logic [7:0] exp_b, input string nm);
        send_cw(lo);
        send_cw(hi);
        chk($sformatf("%s valid@+0", nm), m_valid, 0);
        tick();
        chk($sformatf("%s valid@+1", nm), m_valid, 0);
        tick();
        chk($sformatf("%s valid@+2", nm), m_valid, 1);
        chk($sformatf("%s data", nm), m_data, exp_b);
        tick();
        chk($sformatf("%s valid@+3", nm), m_valid, 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_corr  = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        sync_clr  = 1'b0;
        m_ready   = 1'b1;

        vecs[0] = '{7'h2D, 7'h55, 8'hB5, 0};
        vecs[1] = '{7'h2D, 7'h51, 8'hB5, 1};
        vecs[2] = '{7'h00, 7'h7F, 8'hF0, 0};
        vecs[3] = '{7'h3F, 7'h01, 8'h0F, 2};
        vecs[4] = '{7'h52, 7'h16, 8'h3A, 1};
        vecs[5] = '{7'h1E, 7'h72, 8'hA3, 1};

        tick();
        tick();
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst corr_cnt", corr_cnt, 0);
        chk("rst frame_err_cnt", frame_err_cnt, 0);
        chk("rst overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Table: clean words and single-bit errors at various positions.
        for (int v = 0; v < 6; v++) begin
            send_pair(vecs[v].lo_cw, vecs[v].hi_cw, vecs[v].exp_byte, $sformatf("vec%0d", v));
            exp_corr += vecs[v].corr_inc;
            chk($sformatf("vec%0d corr_cnt", v), corr_cnt, exp_corr);
        end

        // Timeout: 4 bits of 0x55, then idle.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        repeat (TIMEOUT - 1) tick();
        chk("timeout before limit", frame_err_cnt, 0);
        tick();
        chk("timeout at limit", frame_err_cnt, 1);
        send_pair(7'h2D, 7'h55, 8'hB5, "post-timeout");
        chk("post-timeout corr_cnt", corr_cnt, exp_corr);

        // Overflow with m_ready low.
        m_ready = 1'b0;
        send_cw(7'h2D); send_cw(7'h55);
        send_cw(7'h00); send_cw(7'h7F);
        repeat (3) tick();
        chk("full overflow", overflow, 0);
        chk("full head", m_data, 8'hB5);
        send_cw(7'h7F); send_cw(7'h00);
        repeat (3) tick();
        chk("drop overflow", overflow, 1);
        chk("drop valid", m_valid, 1);
        repeat (3) tick();
        chk("stall head stable", m_data, 8'hB5);
        // Pop and push on the same edge while full.
        send_cw(7'h52); send_cw(7'h1E);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("swap head", m_data, 8'hF0);
        chk("swap valid", m_valid, 1);
        m_ready = 1'b1;
        tick();
        chk("swap second", m_data, 8'h3A);
        chk("swap second valid", m_valid, 1);
        tick();
        chk("swap drained", m_valid, 0);
        chk("overflow sticky", overflow, 1);

        // ena low: strobes ignored.
        ena = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        ena = 1'b1;
        send_pair(7'h2D, 7'h55, 8'hB5, "ena-gated");

        // sync_clr beats bit_valid and drops the stored low nibble.
        send_cw(7'h2D);
        tick();
        tick();
        sync_clr  = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        tick();
        sync_clr  = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        send_pair(7'h52, 7'h1E, 8'h3A, "sync_clr");
        chk("sync_clr corr_cnt", corr_cnt, exp_corr);

        // Reset mid-codeword, nibble phase HI, FIFO holding a byte.
        m_ready = 1'b0;
        send_cw(7'h2D); send_cw(7'h55);
        repeat (3) tick();
        chk("pre-rst valid", m_valid, 1);
        send_cw(7'h2D);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid rst m_valid", m_valid, 0);
        chk("mid rst m_data", m_data, 0);
        chk("mid rst corr_cnt", corr_cnt, 0);
        chk("mid rst frame_err_cnt", frame_err_cnt, 0);
        chk("mid rst overflow", overflow, 0);
        rst_n    = 1'b1;
        m_ready  = 1'b1;
        exp_corr = 0;
        send_pair(7'h2D, 7'h55, 8'hB5, "post-rst");
        chk("post-rst corr_cnt", corr_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
